// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the melody sequencer: state encoding and datapath widths.
package tone_seq_defs;

    localparam int TONE_WIDTH     = 24;
    localparam int NOTE_LEN_WIDTH = 24;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2,
        PLAY   = 2'd3
    } state_t;

endpackage

// File: rtl/tone_sequencer_tempo_control.sv
// Note-length register: steps down/up by TEMPO_STEP on tempo pulses, saturating
// at NOTE_LEN_MIN/NOTE_LEN_MAX. Simultaneous up and down pulses cancel.
module tempo_control
    import tone_seq_defs::*;
#(
    parameter int unsigned NOTE_LEN_DEFAULT = 5_000_000,
    parameter int unsigned TEMPO_STEP       = 500_000,
    parameter int unsigned NOTE_LEN_MIN     = 1_000_000,
    parameter int unsigned NOTE_LEN_MAX     = 15_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tempo_up,
    input  logic                      tempo_down,
    output logic [NOTE_LEN_WIDTH-1:0] note_len
);

    localparam logic [NOTE_LEN_WIDTH:0] STEP_W = (NOTE_LEN_WIDTH+1)'(TEMPO_STEP);
    localparam logic [NOTE_LEN_WIDTH:0] MIN_W  = (NOTE_LEN_WIDTH+1)'(NOTE_LEN_MIN);
    localparam logic [NOTE_LEN_WIDTH:0] MAX_W  = (NOTE_LEN_WIDTH+1)'(NOTE_LEN_MAX);

    logic [NOTE_LEN_WIDTH:0] len_wide;
    logic [NOTE_LEN_WIDTH:0] sum_wide;
    logic [NOTE_LEN_WIDTH:0] len_next;

    // One extra bit of headroom so the sum cannot wrap before saturation.
    always_comb begin
        len_wide = {1'b0, note_len};
        sum_wide = len_wide + STEP_W;
        len_next = len_wide;
        if (tempo_up && !tempo_down) begin
            len_next = (len_wide < MIN_W + STEP_W) ? MIN_W : len_wide - STEP_W;
        end else if (tempo_down && !tempo_up) begin
            len_next = (sum_wide > MAX_W) ? MAX_W : sum_wide;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_len <= NOTE_LEN_WIDTH'(NOTE_LEN_DEFAULT);
        end else begin
            note_len <= len_next[NOTE_LEN_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a melody ROM, holding each tone period for note_len cycles,
// with play/pause, direction reversal and tempo control.
module tone_sequencer
    import tone_seq_defs::*;
#(
    parameter int unsigned CLOCK_FREQ       = 125_000_000,
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned NUM_NOTES        = 1024,
    parameter int unsigned NOTE_LEN_DEFAULT = CLOCK_FREQ / 25,
    parameter int unsigned TEMPO_STEP       = 500_000,
    parameter int unsigned NOTE_LEN_MIN     = 1_000_000,
    parameter int unsigned NOTE_LEN_MAX     = 15_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play_pause,
    input  logic                      reverse,
    input  logic                      tempo_up,
    input  logic                      tempo_down,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic [TONE_WIDTH-1:0]     rom_data,
    output logic [TONE_WIDTH-1:0]     tone_period,
    output logic                      tone_enable,
    output logic                      playing,
    output logic                      reversed,
    output logic [NOTE_LEN_WIDTH-1:0] note_len
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NOTES - 1);

    state_t                    state, state_next;
    logic [NOTE_LEN_WIDTH-1:0] counter, counter_next;
    logic [ADDR_WIDTH-1:0]     rom_addr_next, addr_advance;
    logic [TONE_WIDTH-1:0]     tone_period_next;
    logic                      tone_enable_next;
    logic                      reversed_next;
    logic                      pause_pending, pause_pending_next;
    logic                      resume_play, resume_play_next;

    tempo_control #(
        .NOTE_LEN_DEFAULT (NOTE_LEN_DEFAULT),
        .TEMPO_STEP       (TEMPO_STEP),
        .NOTE_LEN_MIN     (NOTE_LEN_MIN),
        .NOTE_LEN_MAX     (NOTE_LEN_MAX)
    ) u_tempo (
        .clk        (clk),
        .rst        (rst),
        .tempo_up   (tempo_up),
        .tempo_down (tempo_down),
        .note_len   (note_len)
    );

    assign playing = (state != PAUSED);

    // Advance uses the registered direction, so a reverse pulse in the same
    // cycle only affects the following note.
    always_comb begin
        if (reversed) begin
            addr_advance = (rom_addr == '0) ? LAST_ADDR : rom_addr - ADDR_WIDTH'(1);
        end else begin
            addr_advance = (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_next         = state;
        counter_next       = counter;
        rom_addr_next      = rom_addr;
        tone_period_next   = tone_period;
        tone_enable_next   = tone_enable;
        pause_pending_next = pause_pending;
        resume_play_next   = resume_play;
        reversed_next      = reversed ^ reverse;

        case (state)
            PAUSED: begin
                tone_enable_next = 1'b0;
                if (play_pause) begin
                    if (resume_play) begin
                        state_next       = PLAY;
                        tone_enable_next = (tone_period != '0);
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                state_next = LOAD;
                if (play_pause) pause_pending_next = 1'b1;
            end
            LOAD: begin
                tone_period_next = rom_data;
                tone_enable_next = (rom_data != '0);
                counter_next     = note_len - NOTE_LEN_WIDTH'(1);
                state_next       = PLAY;
                if (play_pause) pause_pending_next = 1'b1;
            end
            PLAY: begin
                // A pause holds the count so the note resumes where it stopped.
                if (play_pause || pause_pending) begin
                    state_next         = PAUSED;
                    pause_pending_next = 1'b0;
                    resume_play_next   = 1'b1;
                    tone_enable_next   = 1'b0;
                end else if (counter == '0) begin
                    rom_addr_next = addr_advance;
                    state_next    = FETCH;
                end else begin
                    counter_next = counter - NOTE_LEN_WIDTH'(1);
                end
            end
            default: begin
                state_next = PAUSED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PAUSED;
            counter       <= '0;
            rom_addr      <= '0;
            tone_period   <= '0;
            tone_enable   <= 1'b0;
            reversed      <= 1'b0;
            pause_pending <= 1'b0;
            resume_play   <= 1'b0;
        end else begin
            state         <= state_next;
            counter       <= counter_next;
            rom_addr      <= rom_addr_next;
            tone_period   <= tone_period_next;
            tone_enable   <= tone_enable_next;
            reversed      <= reversed_next;
            pause_pending <= pause_pending_next;
            resume_play   <= resume_play_next;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: 4-note ROM, short note lengths, cycle-exact
// checks of playback, pause/resume, reverse, tempo saturation and reset.
module tb_tone_sequencer;

    localparam int ADDR_WIDTH = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  play_pause = 1'b0;
    logic                  reverse = 1'b0;
    logic                  tempo_up = 1'b0;
    logic                  tempo_down = 1'b0;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [23:0]           rom_data = '0;
    logic [23:0]           tone_period;
    logic                  tone_enable;
    logic                  playing;
    logic                  reversed;
    logic [23:0]           note_len;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tone_sequencer #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .NUM_NOTES        (4),
        .NOTE_LEN_DEFAULT (10),
        .TEMPO_STEP       (2),
        .NOTE_LEN_MIN     (4),
        .NOTE_LEN_MAX     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .play_pause  (play_pause),
        .reverse     (reverse),
        .tempo_up    (tempo_up),
        .tempo_down  (tempo_down),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .tone_period (tone_period),
        .tone_enable (tone_enable),
        .playing     (playing),
        .reversed    (reversed),
        .note_len    (note_len)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_lookup(input logic [ADDR_WIDTH-1:0] a);
        case (a)
            10'd0:   return 24'd37500;
            10'd1:   return 24'd42000;
            10'd2:   return 24'd0;
            10'd3:   return 24'd50000;
            default: return 24'd0;
        endcase
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always_ff @(posedge clk) rom_data <= rom_lookup(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("rst_enable",   32'(tone_enable), 32'd0);
        check("rst_period",   32'(tone_period), 32'd0);
        check("rst_addr",     32'(rom_addr),    32'd0);
        check("rst_playing",  32'(playing),     32'd0);
        check("rst_reversed", 32'(reversed),    32'd0);
        check("rst_note_len", 32'(note_len),    32'd10);

        tempo_up = 1'b1; tempo_down = 1'b1;
        tick();
        tempo_up = 1'b0; tempo_down = 1'b0;
        check("both_tempo_10", 32'(note_len), 32'd10);

        // Start playback: cycle 0 is the pulse cycle
        cyc = 0;
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
        check("start_playing", 32'(playing), 32'd1);
        run_to(3);
        check("n0_period", 32'(tone_period), 32'd37500);
        check("n0_enable", 32'(tone_enable), 32'd1);
        run_to(12);
        check("n0_last_addr", 32'(rom_addr), 32'd0);
        run_to(13);
        check("n1_fetch_addr",   32'(rom_addr),    32'd1);
        check("fetch_hold_per",  32'(tone_period), 32'd37500);
        check("fetch_hold_en",   32'(tone_enable), 32'd1);
        run_to(15);
        check("n1_period", 32'(tone_period), 32'd42000);

        // Pause 4 cycles into note 1, hold 50 cycles
        run_to(19);
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
        check("pause_playing", 32'(playing),     32'd0);
        check("pause_enable",  32'(tone_enable), 32'd0);
        check("pause_period",  32'(tone_period), 32'd42000);
        run_to(69);
        check("paused_hold_en",   32'(tone_enable), 32'd0);
        check("paused_hold_addr", 32'(rom_addr),    32'd1);
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
        check("resume_playing", 32'(playing),     32'd1);
        check("resume_enable",  32'(tone_enable), 32'd1);
        run_to(75);
        check("resume_last_addr", 32'(rom_addr), 32'd1);
        run_to(76);
        check("resume_adv_addr", 32'(rom_addr), 32'd2);

        // Rest note, then wrap
        run_to(78);
        check("rest_period", 32'(tone_period), 32'd0);
        check("rest_enable", 32'(tone_enable), 32'd0);
        run_to(90);
        check("n3_period", 32'(tone_period), 32'd50000);
        check("n3_enable", 32'(tone_enable), 32'd1);
        run_to(100);
        check("wrap_addr", 32'(rom_addr), 32'd0);
        run_to(102);
        check("wrap_period", 32'(tone_period), 32'd37500);

        // Reverse mid-note at address 1
        run_to(117);
        reverse = 1'b1;
        tick();
        reverse = 1'b0;
        check("rev_flag",   32'(reversed),    32'd1);
        check("rev_period", 32'(tone_period), 32'd42000);
        run_to(123);
        check("rev_note_done", 32'(rom_addr), 32'd1);
        run_to(124);
        check("rev_addr0", 32'(rom_addr), 32'd0);
        run_to(126);
        check("rev_per0", 32'(tone_period), 32'd37500);
        run_to(136);
        check("rev_addr3", 32'(rom_addr), 32'd3);
        run_to(138);
        check("rev_per3", 32'(tone_period), 32'd50000);
        run_to(148);
        check("rev_addr2", 32'(rom_addr), 32'd2);
        run_to(150);
        check("rev_per2", 32'(tone_period), 32'd0);

        // Tempo up to the lower bound; current note unaffected
        run_to(151);
        repeat (5) begin
            tempo_up = 1'b1;
            tick();
        end
        tempo_up = 1'b0;
        check("tempo_min", 32'(note_len), 32'd4);
        run_to(159);
        check("cur_note_len_kept", 32'(rom_addr), 32'd2);
        run_to(160);
        check("rev_addr1", 32'(rom_addr), 32'd1);
        run_to(165);
        check("short_note_last", 32'(rom_addr), 32'd1);
        run_to(166);
        check("short_note_adv", 32'(rom_addr), 32'd0);

        // Tempo down to the upper bound, then both together
        run_to(168);
        repeat (8) begin
            tempo_down = 1'b1;
            tick();
        end
        tempo_down = 1'b0;
        check("tempo_max", 32'(note_len), 32'd16);
        tempo_up = 1'b1; tempo_down = 1'b1;
        tick();
        tempo_up = 1'b0; tempo_down = 1'b0;
        check("both_tempo_16", 32'(note_len), 32'd16);
        run_to(187);
        check("len14_last", 32'(rom_addr), 32'd3);
        run_to(188);
        check("len14_adv", 32'(rom_addr), 32'd2);

        // Pause during FETCH
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
        run_to(190);
        check("pend_playing", 32'(playing),     32'd1);
        check("pend_period",  32'(tone_period), 32'd0);
        run_to(191);
        check("pend_paused",  32'(playing),     32'd0);
        check("pend_enable",  32'(tone_enable), 32'd0);
        run_to(195);
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
        check("pend_resume", 32'(playing), 32'd1);
        run_to(211);
        check("pend_full_len", 32'(rom_addr), 32'd2);
        run_to(212);
        check("pend_adv", 32'(rom_addr), 32'd1);

        // Reset mid-PLAY
        run_to(218);
        check("pre_rst_period", 32'(tone_period), 32'd42000);
        rst = 1'b1;
        tick();
        check("mid_rst_enable",   32'(tone_enable), 32'd0);
        check("mid_rst_period",   32'(tone_period), 32'd0);
        check("mid_rst_addr",     32'(rom_addr),    32'd0);
        check("mid_rst_playing",  32'(playing),     32'd0);
        check("mid_rst_reversed", 32'(reversed),    32'd0);
        check("mid_rst_note_len", 32'(note_len),    32'd10);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
